e203_soc_pad_top: RTL and testbench
===================================

// Module: e203_soc_pad_top
// PURPOSE
//  Pad-level top of the E203 SoC bring-up shell. Sits directly behind the chip pads and drives every pad output.
//  Provides reset sequencing, oscillator enables and fixed QSPI/PMU pad states.
//  Also provides a low-frequency (lfextclk) tick counter and a minimal JTAG TAP.
//  The TAP exposes IDCODE, BYPASS, GPIO A/B control registers and a status register.
//  The whole block runs on hfextclk; lfextclk and JTAG TCK are sampled as data.
// PARAMETERS
//  IDCODE  32'h1E200A6D  value captured by the IDCODE instruction (bit0 must be 1)
//  IR_W    5             JTAG instruction register width
// PORTS
//  hfextclk                          in   1   sole clock, all flops posedge
//  io_pads_aon_erst_i_ival           in   1   reset, asynchronous, active-high
//  hfxoscen / lfxoscen               out  1   oscillator enables
//  lfextclk                          in   1   low-frequency clock, sampled as data
//  io_pads_jtag_TCK/TMS/TDI_i_ival   in   1   JTAG inputs
//  io_pads_jtag_TDO_o_oval / _o_oe   out  1   JTAG TDO data / enable
//  io_pads_gpioA_i_ival              in   32  GPIO A pad input
//  io_pads_gpioA_o_oval / _o_oe      out  32  GPIO A pad output / enable
//  io_pads_gpioB_i_ival, _o_oval, _o_oe   in/out/out  32  same for GPIO B
//  io_pads_qspi0_sck_o_oval, _cs_0_o_oval      out  1   QSPI clock / chip select
//  io_pads_qspi0_dq_[0..3]_i_ival              in   1   QSPI data in (unused)
//  io_pads_qspi0_dq_[0..3]_o_oval / _o_oe      out  1   QSPI data out / enable
//  io_pads_aon_pmu_dwakeup_n_i_ival            in   1   wakeup request, active-low
//  io_pads_aon_pmu_vddpaden_o_oval, _padrst_o_oval   out  1   PMU pad outputs
//  io_pads_bootrom_n_i_ival, io_pads_dbgmode[0..2]_n_i_ival   in  1   strap inputs
// BEHAVIOUR
//  Reset: asynchronous assertion; deassertion is synchronised by a 2-flop chain (rst_int low 2 clocks after release).
//  All state below is cleared while rst_int is high.
//  hfxoscen=1 and lfxoscen=1 always, including during reset.
//  padrst=rst_int.
//  vddpaden=~rst_int.
//  qspi: sck=0, cs_0=1, dq_x_o_oval=0, dq_x_o_oe=0 always.
//  Input sampling: every asynchronous input (TCK, TMS, TDI, lfextclk, straps, dwakeup_n, gpio_i) passes 2 sync flops.
//  Edges: edges are detected on the synchronised TCK and lfextclk.
//  Input latency: 3 clocks from pad to detected edge.
//  Clock-ratio requirement: TCK and lfextclk high and low phases must each be >=4 hfextclk cycles.
//  LF counter: lf_cnt[31:0] increments on each synchronised lfextclk rising edge.
//  LF counter wraps from FFFFFFFF to 0. Reset value is 0.
//  TAP FSM: the 16 standard IEEE 1149.1 states, advanced on detected TCK rise using sync TMS.
//  TAP reset state: Test-Logic-Reset at reset.
//  TAP reset by TMS: 5 TCK rises with TMS=1 reach Test-Logic-Reset from any state.
//  IR: IR_W bits. Test-Logic-Reset loads IDCODE (5'h01).
//  IR capture: Capture-IR loads 5'b00001.
//  IR shift and update: IR shifts LSB-first, TDI enters the MSB. Update-IR commits the shifted value.
//  Instructions: 01 IDCODE (32b), 10 GPIOA (64b), 11 GPIOB (64b), 12 STATUS (8b), 13 LFCNT (32b).
//  Any other instruction selects BYPASS: 1 bit, captures 0.
//  DR capture, IDCODE: loads IDCODE.
//  DR capture, GPIOx: loads {sync gpioX_i[31:0], gpioX_oval_reg[31:0]}.
//  DR capture, STATUS: loads {3'b0, dwakeup_n, dbgmode2_n, dbgmode1_n, dbgmode0_n, bootrom_n} (all synchronised).
//  DR capture, LFCNT: loads lf_cnt.
//  DR shift: LSB-first, TDI enters the MSB of the selected register.
//  DR update, GPIOx: writes gpioX_o_oe = shift[63:32] and gpioX_o_oval = shift[31:0].
//  DR update, other instructions: no effect.
//  GPIO outputs: reset oval=0, oe=0.
//  GPIO outputs change one clock after the Update-DR state is entered.
//  TDO: updated on detected TCK fall with the LSB of the active shift register (IR or DR).
//  TDO_oe: 1 only while in Shift-IR or Shift-DR. TDO_oval=0 at reset.
//  Simultaneous events: a TCK edge and an lfextclk edge in the same cycle are both processed.
//  Reset mid-shift: aborts the shift; GPIO registers clear.
// TESTING
//  Reset: assert reset, release.
//    -> padrst 1->0 after 2 clocks, vddpaden 0->1, qspi cs=1, gpio oe=0, TDO_oe=0.
//  IDCODE: TMS 11111 then 0100, shift 32 bits.
//    -> TDO yields 0x1E200A6D LSB-first.
//    -> TDO_oe is high throughout the shift.
//  GPIO A write: IR=10, shift {32'h0000FFFF, 32'hA5A5_0F0F}, Update-DR.
//    -> gpioA_o_oe=0000FFFF, gpioA_o_oval=A5A50F0F.
//    -> gpioB outputs are unchanged.
//  GPIO readback: gpioA_i=12345678, IR=10, capture and shift.
//    -> first 32 TDO bits = A5A50F0F, next 32 = 12345678.
//  LF counter: 10 lfextclk periods, IR=13, capture.
//    -> shifted value = 10.
//    -> preset near FFFFFFFF: the count wraps to 0.
//  Bypass and STATUS: IR=1F, shift 1,0,1.
//    -> TDO = 0 then TDI delayed by one bit.
//    -> IR=12 with straps 0/1/1/1 and dwakeup_n=1 -> 8'h1E.

Source files
------------

// File: rtl/e203_soc_pad_top.sv
// E203 SoC pad-level bring-up shell: reset sequencing, fixed pad states,
// an lfextclk tick counter and a small JTAG TAP, all clocked by hfextclk.
module e203_soc_pad_top #(
   parameter logic [31:0] IDCODE = 32'h1E200A6D,
   parameter int unsigned IR_W   = 5
) (
   input  logic        hfextclk,
   input  logic        io_pads_aon_erst_i_ival,
   output logic        hfxoscen,
   output logic        lfxoscen,
   input  logic        lfextclk,
   input  logic        io_pads_jtag_TCK_i_ival,
   input  logic        io_pads_jtag_TMS_i_ival,
   input  logic        io_pads_jtag_TDI_i_ival,
   output logic        io_pads_jtag_TDO_o_oval,
   output logic        io_pads_jtag_TDO_o_oe,
   input  logic [31:0] io_pads_gpioA_i_ival,
   output logic [31:0] io_pads_gpioA_o_oval,
   output logic [31:0] io_pads_gpioA_o_oe,
   input  logic [31:0] io_pads_gpioB_i_ival,
   output logic [31:0] io_pads_gpioB_o_oval,
   output logic [31:0] io_pads_gpioB_o_oe,
   output logic        io_pads_qspi0_sck_o_oval,
   output logic        io_pads_qspi0_cs_0_o_oval,
   input  logic        io_pads_qspi0_dq_0_i_ival,
   output logic        io_pads_qspi0_dq_0_o_oval,
   output logic        io_pads_qspi0_dq_0_o_oe,
   input  logic        io_pads_qspi0_dq_1_i_ival,
   output logic        io_pads_qspi0_dq_1_o_oval,
   output logic        io_pads_qspi0_dq_1_o_oe,
   input  logic        io_pads_qspi0_dq_2_i_ival,
   output logic        io_pads_qspi0_dq_2_o_oval,
   output logic        io_pads_qspi0_dq_2_o_oe,
   input  logic        io_pads_qspi0_dq_3_i_ival,
   output logic        io_pads_qspi0_dq_3_o_oval,
   output logic        io_pads_qspi0_dq_3_o_oe,
   input  logic        io_pads_aon_pmu_dwakeup_n_i_ival,
   output logic        io_pads_aon_pmu_vddpaden_o_oval,
   output logic        io_pads_aon_pmu_padrst_o_oval,
   input  logic        io_pads_bootrom_n_i_ival,
   input  logic        io_pads_dbgmode0_n_i_ival,
   input  logic        io_pads_dbgmode1_n_i_ival,
   input  logic        io_pads_dbgmode2_n_i_ival
);

   localparam logic [IR_W-1:0] IR_IDCODE = IR_W'('h01);
   localparam logic [IR_W-1:0] IR_GPIOA  = IR_W'('h10);
   localparam logic [IR_W-1:0] IR_GPIOB  = IR_W'('h11);
   localparam logic [IR_W-1:0] IR_STATUS = IR_W'('h12);
   localparam logic [IR_W-1:0] IR_LFCNT  = IR_W'('h13);
   localparam int SW = 73;

   typedef enum logic [3:0] {
      TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR,
      UPD_DR, SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
   } tap_e;

   logic [1:0]      rst_sync_q;
   logic            rst_int;
   logic [SW-1:0]   pad_in, s1_q, s2_q;
   logic            tck_p_q, lf_p_q;
   logic            tck_rise, tck_fall, lf_rise;
   logic            tms, tdi;
   logic [31:0]     gpa_in, gpb_in;
   logic [7:0]      status;
   tap_e            tap_q, tap_d;
   logic            adv_q;
   logic [IR_W-1:0] ir_q, ir_d, irsh_q, irsh_d;
   logic [63:0]     dr_q, dr_d, dr_cap, dr_sh;
   logic            tdo_q, tdo_d;
   logic [31:0]     lf_cnt_q, lf_cnt_d;
   logic [31:0]     gpa_oval_q, gpa_oval_d, gpa_oe_q, gpa_oe_d;
   logic [31:0]     gpb_oval_q, gpb_oval_d, gpb_oe_q, gpb_oe_d;
   logic            unused_qspi;

   // Release is stretched two clocks so everything leaves reset cleanly.
   always_ff @(posedge hfextclk or posedge io_pads_aon_erst_i_ival) begin
      if (io_pads_aon_erst_i_ival) rst_sync_q <= 2'b11;
      else                         rst_sync_q <= {rst_sync_q[0], 1'b0};
   end
   assign rst_int = rst_sync_q[1];

   assign pad_in = {io_pads_gpioB_i_ival, io_pads_gpioA_i_ival,
                    io_pads_aon_pmu_dwakeup_n_i_ival,
                    io_pads_dbgmode2_n_i_ival, io_pads_dbgmode1_n_i_ival,
                    io_pads_dbgmode0_n_i_ival, io_pads_bootrom_n_i_ival,
                    lfextclk, io_pads_jtag_TDI_i_ival,
                    io_pads_jtag_TMS_i_ival, io_pads_jtag_TCK_i_ival};

   always_ff @(posedge hfextclk or posedge rst_int) begin
      if (rst_int) begin
         s1_q    <= '0;
         s2_q    <= '0;
         tck_p_q <= 1'b0;
         lf_p_q  <= 1'b0;
      end else begin
         s1_q    <= pad_in;
         s2_q    <= s1_q;
         tck_p_q <= s2_q[0];
         lf_p_q  <= s2_q[3];
      end
   end

   assign tck_rise = s2_q[0] & ~tck_p_q;
   assign tck_fall = ~s2_q[0] & tck_p_q;
   assign lf_rise  = s2_q[3] & ~lf_p_q;
   assign tms      = s2_q[1];
   assign tdi      = s2_q[2];
   assign status   = {3'b000, s2_q[8:4]};
   assign gpa_in   = s2_q[40:9];
   assign gpb_in   = s2_q[72:41];

   always_comb begin
      tap_d = tap_q;
      if (tck_rise) begin
         unique case (tap_q)
            TLR:    tap_d = tms ? TLR    : RTI;
            RTI:    tap_d = tms ? SEL_DR : RTI;
            SEL_DR: tap_d = tms ? SEL_IR : CAP_DR;
            CAP_DR: tap_d = tms ? EX1_DR : SH_DR;
            SH_DR:  tap_d = tms ? EX1_DR : SH_DR;
            EX1_DR: tap_d = tms ? UPD_DR : PAU_DR;
            PAU_DR: tap_d = tms ? EX2_DR : PAU_DR;
            EX2_DR: tap_d = tms ? UPD_DR : SH_DR;
            UPD_DR: tap_d = tms ? SEL_DR : RTI;
            SEL_IR: tap_d = tms ? TLR    : CAP_IR;
            CAP_IR: tap_d = tms ? EX1_IR : SH_IR;
            SH_IR:  tap_d = tms ? EX1_IR : SH_IR;
            EX1_IR: tap_d = tms ? UPD_IR : PAU_IR;
            PAU_IR: tap_d = tms ? EX2_IR : PAU_IR;
            EX2_IR: tap_d = tms ? UPD_IR : SH_IR;
            UPD_IR: tap_d = tms ? SEL_DR : RTI;
         endcase
      end
   end

   // Each instruction owns a DR of its own length; TDI enters its MSB.
   always_comb begin
      unique case (ir_q)
         IR_IDCODE: begin
            dr_cap = {32'b0, IDCODE};
            dr_sh  = {32'b0, tdi, dr_q[31:1]};
         end
         IR_GPIOA: begin
            dr_cap = {gpa_in, gpa_oval_q};
            dr_sh  = {tdi, dr_q[63:1]};
         end
         IR_GPIOB: begin
            dr_cap = {gpb_in, gpb_oval_q};
            dr_sh  = {tdi, dr_q[63:1]};
         end
         IR_STATUS: begin
            dr_cap = {56'b0, status};
            dr_sh  = {56'b0, tdi, dr_q[7:1]};
         end
         IR_LFCNT: begin
            dr_cap = {32'b0, lf_cnt_q};
            dr_sh  = {32'b0, tdi, dr_q[31:1]};
         end
         default: begin
            dr_cap = 64'b0;
            dr_sh  = {63'b0, tdi};
         end
      endcase
   end

   always_comb begin
      ir_d       = ir_q;
      irsh_d     = irsh_q;
      dr_d       = dr_q;
      tdo_d      = tdo_q;
      gpa_oval_d = gpa_oval_q;
      gpa_oe_d   = gpa_oe_q;
      gpb_oval_d = gpb_oval_q;
      gpb_oe_d   = gpb_oe_q;
      lf_cnt_d   = lf_cnt_q + 32'(lf_rise);
      if (tck_rise) begin
         unique case (1'b1)
            tap_q == CAP_IR: irsh_d = IR_W'('h01);
            tap_q == SH_IR:  irsh_d = {tdi, irsh_q[IR_W-1:1]};
            tap_q == CAP_DR: dr_d   = dr_cap;
            tap_q == SH_DR:  dr_d   = dr_sh;
            default: ;
         endcase
      end
      if (tck_fall) tdo_d = (tap_q == SH_IR) ? irsh_q[0] : dr_q[0];
      if (tap_q == TLR) ir_d = IR_IDCODE;
      // adv_q marks the first clock spent in a freshly entered state.
      if (adv_q && tap_q == UPD_IR) ir_d = irsh_q;
      if (adv_q && tap_q == UPD_DR) begin
         if (ir_q == IR_GPIOA) begin
            gpa_oe_d   = dr_q[63:32];
            gpa_oval_d = dr_q[31:0];
         end
         if (ir_q == IR_GPIOB) begin
            gpb_oe_d   = dr_q[63:32];
            gpb_oval_d = dr_q[31:0];
         end
      end
   end

   always_ff @(posedge hfextclk or posedge rst_int) begin
      if (rst_int) begin
         tap_q      <= TLR;
         adv_q      <= 1'b0;
         ir_q       <= IR_IDCODE;
         irsh_q     <= '0;
         dr_q       <= '0;
         tdo_q      <= 1'b0;
         lf_cnt_q   <= '0;
         gpa_oval_q <= '0;
         gpa_oe_q   <= '0;
         gpb_oval_q <= '0;
         gpb_oe_q   <= '0;
      end else begin
         tap_q      <= tap_d;
         adv_q      <= tck_rise;
         ir_q       <= ir_d;
         irsh_q     <= irsh_d;
         dr_q       <= dr_d;
         tdo_q      <= tdo_d;
         lf_cnt_q   <= lf_cnt_d;
         gpa_oval_q <= gpa_oval_d;
         gpa_oe_q   <= gpa_oe_d;
         gpb_oval_q <= gpb_oval_d;
         gpb_oe_q   <= gpb_oe_d;
      end
   end

   assign hfxoscen = 1'b1;
   assign lfxoscen = 1'b1;
   assign io_pads_aon_pmu_padrst_o_oval   = rst_int;
   assign io_pads_aon_pmu_vddpaden_o_oval = ~rst_int;
   assign io_pads_jtag_TDO_o_oval = tdo_q;
   assign io_pads_jtag_TDO_o_oe   = (tap_q == SH_IR) || (tap_q == SH_DR);
   assign io_pads_gpioA_o_oval = gpa_oval_q;
   assign io_pads_gpioA_o_oe   = gpa_oe_q;
   assign io_pads_gpioB_o_oval = gpb_oval_q;
   assign io_pads_gpioB_o_oe   = gpb_oe_q;
   assign io_pads_qspi0_sck_o_oval  = 1'b0;
   assign io_pads_qspi0_cs_0_o_oval = 1'b1;
   assign io_pads_qspi0_dq_0_o_oval = 1'b0;
   assign io_pads_qspi0_dq_0_o_oe   = 1'b0;
   assign io_pads_qspi0_dq_1_o_oval = 1'b0;
   assign io_pads_qspi0_dq_1_o_oe   = 1'b0;
   assign io_pads_qspi0_dq_2_o_oval = 1'b0;
   assign io_pads_qspi0_dq_2_o_oe   = 1'b0;
   assign io_pads_qspi0_dq_3_o_oval = 1'b0;
   assign io_pads_qspi0_dq_3_o_oe   = 1'b0;
   assign unused_qspi = ^{io_pads_qspi0_dq_0_i_ival, io_pads_qspi0_dq_1_i_ival,
                          io_pads_qspi0_dq_2_i_ival, io_pads_qspi0_dq_3_i_ival};

endmodule

// File: tb/tb_e203_soc_pad_top.sv
// Directed bench for the E203 pad shell: reset, JTAG TAP registers,
// GPIO control, lfextclk counter and bypass/status paths.
module tb_e203_soc_pad_top;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        hfxoscen, lfxoscen;
   logic        lf = 1'b0;
   logic        tck = 1'b0, tms = 1'b0, tdi = 1'b0;
   logic        tdo, tdo_oe;
   logic [31:0] ga_i = '0, ga_oval, ga_oe;
   logic [31:0] gb_i = '0, gb_oval, gb_oe;
   logic        sck, cs0;
   logic [3:0]  dq_i = '0, dq_oval, dq_oe;
   logic        dwake = 1'b1, vddpaden, padrst;
   logic        boot = 1'b1, dbg0 = 1'b1, dbg1 = 1'b1, dbg2 = 1'b1;

   int checks = 0;
   int errors = 0;

   localparam logic [31:0] IDC = 32'h1E200A6D;

   e203_soc_pad_top dut (
      .hfextclk                        (clk),
      .io_pads_aon_erst_i_ival         (rst),
      .hfxoscen                        (hfxoscen),
      .lfxoscen                        (lfxoscen),
      .lfextclk                        (lf),
      .io_pads_jtag_TCK_i_ival         (tck),
      .io_pads_jtag_TMS_i_ival         (tms),
      .io_pads_jtag_TDI_i_ival         (tdi),
      .io_pads_jtag_TDO_o_oval         (tdo),
      .io_pads_jtag_TDO_o_oe           (tdo_oe),
      .io_pads_gpioA_i_ival            (ga_i),
      .io_pads_gpioA_o_oval            (ga_oval),
      .io_pads_gpioA_o_oe              (ga_oe),
      .io_pads_gpioB_i_ival            (gb_i),
      .io_pads_gpioB_o_oval            (gb_oval),
      .io_pads_gpioB_o_oe              (gb_oe),
      .io_pads_qspi0_sck_o_oval        (sck),
      .io_pads_qspi0_cs_0_o_oval       (cs0),
      .io_pads_qspi0_dq_0_i_ival       (dq_i[0]),
      .io_pads_qspi0_dq_0_o_oval       (dq_oval[0]),
      .io_pads_qspi0_dq_0_o_oe         (dq_oe[0]),
      .io_pads_qspi0_dq_1_i_ival       (dq_i[1]),
      .io_pads_qspi0_dq_1_o_oval       (dq_oval[1]),
      .io_pads_qspi0_dq_1_o_oe         (dq_oe[1]),
      .io_pads_qspi0_dq_2_i_ival       (dq_i[2]),
      .io_pads_qspi0_dq_2_o_oval       (dq_oval[2]),
      .io_pads_qspi0_dq_2_o_oe         (dq_oe[2]),
      .io_pads_qspi0_dq_3_i_ival       (dq_i[3]),
      .io_pads_qspi0_dq_3_o_oval       (dq_oval[3]),
      .io_pads_qspi0_dq_3_o_oe         (dq_oe[3]),
      .io_pads_aon_pmu_dwakeup_n_i_ival(dwake),
      .io_pads_aon_pmu_vddpaden_o_oval (vddpaden),
      .io_pads_aon_pmu_padrst_o_oval   (padrst),
      .io_pads_bootrom_n_i_ival        (boot),
      .io_pads_dbgmode0_n_i_ival       (dbg0),
      .io_pads_dbgmode1_n_i_ival       (dbg1),
      .io_pads_dbgmode2_n_i_ival       (dbg2)
   );

   always #5 clk = ~clk;

   // One TCK period; TDO/oe are sampled before the rising edge.
   task automatic tck_pulse(input logic m, input logic d,
                            output logic o, output logic e);
      @(negedge clk);
      o = tdo;
      e = tdo_oe;
      tms = m;
      tdi = d;
      @(negedge clk);
      tck = 1'b1;
      repeat (6) @(negedge clk);
      tck = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic tap_reset();
      logic o, e;
      for (int i = 0; i < 5; i++) tck_pulse(1'b1, 1'b0, o, e);
      tck_pulse(1'b0, 1'b0, o, e);
   endtask

   // From Run-Test/Idle back to Run-Test/Idle.
   task automatic shift_ir(input logic [4:0] din, output logic [4:0] dout);
      logic o, e;
      tck_pulse(1'b1, 1'b0, o, e);
      tck_pulse(1'b1, 1'b0, o, e);
      tck_pulse(1'b0, 1'b0, o, e);
      tck_pulse(1'b0, 1'b0, o, e);
      for (int i = 0; i < 5; i++) begin
         tck_pulse(i == 4, din[i], o, e);
         dout[i] = o;
      end
      tck_pulse(1'b1, 1'b0, o, e);
      tck_pulse(1'b0, 1'b0, o, e);
   endtask

   task automatic shift_dr(input logic [63:0] din, input int n,
                           output logic [63:0] dout, output int oebad);
      logic o, e;
      dout = '0;
      oebad = 0;
      tck_pulse(1'b1, 1'b0, o, e);
      tck_pulse(1'b0, 1'b0, o, e);
      tck_pulse(1'b0, 1'b0, o, e);
      for (int i = 0; i < n; i++) begin
         tck_pulse(i == n - 1, din[i], o, e);
         dout[i] = o;
         if (e !== 1'b1) oebad++;
      end
      tck_pulse(1'b1, 1'b0, o, e);
      tck_pulse(1'b0, 1'b0, o, e);
   endtask

   task automatic lf_periods(input int n);
      for (int i = 0; i < n; i++) begin
         lf = 1'b1;
         repeat (5) @(negedge clk);
         lf = 1'b0;
         repeat (5) @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({padrst, vddpaden} !== 2'b10) begin
         errors++;
         $display("FAIL rst_active pmu: got %b expected 10", {padrst, vddpaden});
      end
      checks++;
      if ({hfxoscen, lfxoscen} !== 2'b11) begin
         errors++;
         $display("FAIL rst_active osc: got %b expected 11", {hfxoscen, lfxoscen});
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (padrst !== 1'b1) begin
         errors++;
         $display("FAIL rst_release1 padrst: got %b expected 1", padrst);
      end
      @(negedge clk);
      checks++;
      if ({padrst, vddpaden} !== 2'b01) begin
         errors++;
         $display("FAIL rst_release2 pmu: got %b expected 01", {padrst, vddpaden});
      end
      checks++;
      if ({sck, cs0, dq_oval, dq_oe} !== 10'b01_0000_0000) begin
         errors++;
         $display("FAIL rst qspi: got %b expected 0100000000",
                  {sck, cs0, dq_oval, dq_oe});
      end
      checks++;
      if ({ga_oe, ga_oval, gb_oe, gb_oval} !== 128'b0) begin
         errors++;
         $display("FAIL rst gpio: got %h %h %h %h expected 0",
                  ga_oe, ga_oval, gb_oe, gb_oval);
      end
      checks++;
      if ({tdo_oe, tdo} !== 2'b00) begin
         errors++;
         $display("FAIL rst tdo: got %b expected 00", {tdo_oe, tdo});
      end
      checks++;
      if ({hfxoscen, lfxoscen} !== 2'b11) begin
         errors++;
         $display("FAIL run osc: got %b expected 11", {hfxoscen, lfxoscen});
      end
   endtask

   task automatic test_idcode();
      logic [63:0] d;
      int ob;
      tap_reset();
      shift_dr(64'h0, 32, d, ob);
      checks++;
      if (d[31:0] !== IDC) begin
         errors++;
         $display("FAIL idcode: got %h expected %h", d[31:0], IDC);
      end
      checks++;
      if (ob !== 0) begin
         errors++;
         $display("FAIL idcode oe: got %0d low bits expected 0", ob);
      end
   endtask

   task automatic test_gpio_write();
      logic [4:0] ic;
      logic [63:0] d;
      int ob;
      shift_ir(5'h10, ic);
      checks++;
      if (ic !== 5'b00001) begin
         errors++;
         $display("FAIL ir_capture: got %b expected 00001", ic);
      end
      shift_dr(64'h0000FFFF_A5A50F0F, 64, d, ob);
      checks++;
      if (d !== 64'h0) begin
         errors++;
         $display("FAIL gpioA first capture: got %h expected 0", d);
      end
      checks++;
      if ({ga_oe, ga_oval} !== 64'h0000FFFF_A5A50F0F) begin
         errors++;
         $display("FAIL gpioA write: got %h %h expected 0000ffff a5a50f0f",
                  ga_oe, ga_oval);
      end
      checks++;
      if ({gb_oe, gb_oval} !== 64'h0) begin
         errors++;
         $display("FAIL gpioB untouched: got %h %h expected 0", gb_oe, gb_oval);
      end
      checks++;
      if (ob !== 0) begin
         errors++;
         $display("FAIL gpioA oe during shift: got %0d low bits expected 0", ob);
      end
   endtask

   task automatic test_gpio_readback();
      logic [4:0] ic;
      logic [63:0] d;
      int ob;
      ga_i = 32'h12345678;
      gb_i = 32'hCAFE0001;
      shift_ir(5'h10, ic);
      shift_dr(64'h0000FFFF_A5A50F0F, 64, d, ob);
      checks++;
      if (d[31:0] !== 32'hA5A50F0F) begin
         errors++;
         $display("FAIL gpioA readback oval: got %h expected a5a50f0f", d[31:0]);
      end
      checks++;
      if (d[63:32] !== 32'h12345678) begin
         errors++;
         $display("FAIL gpioA readback pad: got %h expected 12345678", d[63:32]);
      end
      shift_ir(5'h11, ic);
      shift_dr(64'hFFFF0000_00001234, 64, d, ob);
      checks++;
      if (d !== 64'hCAFE0001_00000000) begin
         errors++;
         $display("FAIL gpioB capture: got %h expected cafe000100000000", d);
      end
      checks++;
      if ({gb_oe, gb_oval} !== 64'hFFFF0000_00001234) begin
         errors++;
         $display("FAIL gpioB write: got %h %h expected ffff0000 00001234",
                  gb_oe, gb_oval);
      end
      checks++;
      if ({ga_oe, ga_oval} !== 64'h0000FFFF_A5A50F0F) begin
         errors++;
         $display("FAIL gpioA held: got %h %h expected 0000ffff a5a50f0f",
                  ga_oe, ga_oval);
      end
   endtask

   task automatic test_lf_counter();
      logic [4:0] ic;
      logic [63:0] d;
      int ob;
      fork
         lf_periods(10);
         shift_ir(5'h13, ic);
      join
      shift_dr(64'h0, 32, d, ob);
      checks++;
      if (d[31:0] !== 32'd10) begin
         errors++;
         $display("FAIL lf count: got %0d expected 10", d[31:0]);
      end
      force dut.lf_cnt_q = 32'hFFFF_FFFE;
      repeat (2) @(negedge clk);
      release dut.lf_cnt_q;
      lf_periods(2);
      shift_dr(64'h0, 32, d, ob);
      checks++;
      if (d[31:0] !== 32'h0) begin
         errors++;
         $display("FAIL lf wrap: got %h expected 00000000", d[31:0]);
      end
   endtask

   task automatic test_bypass_status();
      logic [4:0] ic;
      logic [63:0] d;
      int ob;
      shift_ir(5'h1F, ic);
      shift_dr(64'h5, 3, d, ob);
      checks++;
      if (d[2:0] !== 3'b010) begin
         errors++;
         $display("FAIL bypass: got %b expected 010", d[2:0]);
      end
      boot = 1'b0; dbg0 = 1'b1; dbg1 = 1'b1; dbg2 = 1'b1; dwake = 1'b1;
      shift_ir(5'h12, ic);
      shift_dr(64'h0, 8, d, ob);
      checks++;
      if (d[7:0] !== 8'h1E) begin
         errors++;
         $display("FAIL status 1e: got %h expected 1e", d[7:0]);
      end
      boot = 1'b1; dbg0 = 1'b0; dbg1 = 1'b1; dbg2 = 1'b0; dwake = 1'b0;
      shift_dr(64'h0, 8, d, ob);
      checks++;
      if (d[7:0] !== 8'h05) begin
         errors++;
         $display("FAIL status 05: got %h expected 05", d[7:0]);
      end
   endtask

   task automatic test_reset_mid_shift();
      logic [4:0] ic;
      logic [63:0] d;
      logic o, e;
      int ob;
      shift_ir(5'h10, ic);
      tck_pulse(1'b1, 1'b0, o, e);
      tck_pulse(1'b0, 1'b0, o, e);
      tck_pulse(1'b0, 1'b0, o, e);
      for (int i = 0; i < 10; i++) tck_pulse(1'b0, 1'b1, o, e);
      checks++;
      if (tdo_oe !== 1'b1) begin
         errors++;
         $display("FAIL midshift oe: got %b expected 1", tdo_oe);
      end
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({ga_oe, ga_oval, gb_oe, gb_oval} !== 128'b0) begin
         errors++;
         $display("FAIL midshift gpio clear: got %h %h %h %h expected 0",
                  ga_oe, ga_oval, gb_oe, gb_oval);
      end
      checks++;
      if (tdo_oe !== 1'b0) begin
         errors++;
         $display("FAIL midshift oe clear: got %b expected 0", tdo_oe);
      end
      rst = 1'b0;
      repeat (4) @(negedge clk);
      tck_pulse(1'b0, 1'b0, o, e);
      shift_dr(64'h0, 32, d, ob);
      checks++;
      if (d[31:0] !== IDC) begin
         errors++;
         $display("FAIL midshift idcode: got %h expected %h", d[31:0], IDC);
      end
   endtask

   initial begin
      test_reset();
      test_idcode();
      test_gpio_write();
      test_gpio_readback();
      test_lf_counter();
      test_bypass_status();
      test_reset_mid_shift();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
